// File: rtl/vga_pkg.sv
// Shared widths, screen constants and FSM state type for the
// rectangle fill engine.
package vga_pkg;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;
    localparam int MAX_X    = 160;
    localparam int MAX_Y    = 120;

    typedef logic [COLOUR_W-1:0] colour_t;

    typedef enum logic {
        IDLE,
        FILL
    } rect_state_t;
endpackage

// File: rtl/vga_rect_fill_if.sv
// Command and pixel-port bundle between drawing logic and the fill engine.
interface vga_rect_fill_if;
    import vga_pkg::*;

    logic                start;
    logic [X_W-1:0]      x0;
    logic [Y_W-1:0]      y0;
    logic [X_W-1:0]      w;
    logic [Y_W-1:0]      h;
    colour_t             colour_in;
    logic                busy;
    logic                done;
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    colour_t             colour;
    logic                plot;

    modport master (
        output start, x0, y0, w, h, colour_in,
        input  busy, done, x, y, colour, plot
    );

    modport slave (
        input  start, x0, y0, w, h, colour_in,
        output busy, done, x, y, colour, plot
    );
endinterface

// File: rtl/vga_rect_fill_raster_counter.sv
// Column/row raster counters for the fill engine; col_nx/row_nx give
// the position that will be current after the next edge.
module raster_counter
    import vga_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    input  logic           en,
    input  logic [X_W-1:0] w,
    input  logic [Y_W-1:0] h,
    output logic [X_W-1:0] col_nx,
    output logic [Y_W-1:0] row_nx,
    output logic           last,
    output logic           advance
);
    logic [X_W-1:0] col_q, col_d;
    logic [Y_W-1:0] row_q, row_d;
    logic           col_wrap;

    assign col_wrap = (col_q == w - X_W'(1));
    assign last     = col_wrap && (row_q == h - Y_W'(1));
    assign advance  = en && !last;
    assign col_nx   = col_d;
    assign row_nx   = row_d;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear) begin
            col_d = '0;
            row_d = '0;
        end else if (advance) begin
            col_d = col_wrap ? '0 : col_q + X_W'(1);
            row_d = col_wrap ? row_q + Y_W'(1) : row_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end
endmodule

// File: rtl/vga_rect_fill.sv
// Rectangle fill engine: one pixel per clock in raster order.
// Define VGA_RECT_CLIP_EN to suppress plot for off-screen pixels.
module vga_rect_fill
    import vga_pkg::*;
(
    input  logic           CLOCK_50,
    input  logic           reset,
    vga_rect_fill_if.slave bus
);
    rect_state_t    state_q, state_d;
    logic [X_W-1:0] x0_q, x0_d, w_q, w_d, x_q, x_d;
    logic [Y_W-1:0] y0_q, y0_d, h_q, h_d, y_q, y_d;
    colour_t        fc_q, fc_d, colour_q, colour_d;
    logic           plot_q, plot_d, busy_q, busy_d, done_q, done_d;

    logic           clear, pix_vld, in_scr;
    logic [X_W-1:0] col_nx, bx, px;
    logic [Y_W-1:0] row_nx, by, py;
    colour_t        bc;
    logic           last, advance;
`ifdef VGA_RECT_CLIP_EN
    logic [X_W:0]   ux;
    logic [Y_W:0]   uy;
`endif

    raster_counter u_cnt (
        .clk     (CLOCK_50),
        .rst     (reset),
        .clear   (clear),
        .en      (state_q == FILL),
        .w       (w_q),
        .h       (h_q),
        .col_nx  (col_nx),
        .row_nx  (row_nx),
        .last    (last),
        .advance (advance)
    );

    always_comb begin
        state_d  = state_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        w_d      = w_q;
        h_d      = h_q;
        fc_d     = fc_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        clear    = 1'b0;
        pix_vld  = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    x0_d = bus.x0;
                    y0_d = bus.y0;
                    w_d  = bus.w;
                    h_d  = bus.h;
                    fc_d = bus.colour_in;
                    if (bus.w == '0 || bus.h == '0) begin
                        done_d = 1'b1;
                    end else begin
                        clear   = 1'b1;
                        pix_vld = 1'b1;
                        busy_d  = 1'b1;
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                if (advance) begin
                    pix_vld = 1'b1;
                end else if (last) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // First pixel comes straight from the command inputs.
        bx = (state_q == IDLE) ? bus.x0 : x0_q;
        by = (state_q == IDLE) ? bus.y0 : y0_q;
        bc = (state_q == IDLE) ? bus.colour_in : fc_q;
`ifdef VGA_RECT_CLIP_EN
        ux     = {1'b0, bx} + {1'b0, col_nx};
        uy     = {1'b0, by} + {1'b0, row_nx};
        px     = ux[X_W-1:0];
        py     = uy[Y_W-1:0];
        in_scr = (int'(ux) < MAX_X) && (int'(uy) < MAX_Y);
`else
        px     = bx + col_nx;
        py     = by + row_nx;
        in_scr = 1'b1;
`endif
        plot_d   = pix_vld && in_scr;
        x_d      = plot_d ? px : x_q;
        y_d      = plot_d ? py : y_q;
        colour_d = plot_d ? bc : colour_q;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q  <= IDLE;
            x0_q     <= '0;
            y0_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            fc_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            w_q      <= w_d;
            h_q      <= h_d;
            fc_q     <= fc_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.colour = colour_q;
    assign bus.plot   = plot_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: doc/vga_rect_fill.md
# vga_rect_fill

Rectangle fill engine sitting directly upstream of the VGA pixel port (`x`, `y`, `colour`, `plot`) of the top-level design. On a start request it latches a rectangle origin, size and colour, then emits one pixel per clock in raster order with `plot` asserted. It gives drawing logic (game/FSM code driven from `SW`/`KEY`) a single-command way to paint blocks or clear regions.

## Interface
- `MAX_X`, 160: screen width in pixels; used only for clipping.
- `MAX_Y`, 120: screen height in pixels; used only for clipping.

Ports:
- `CLOCK_50` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: request; accepted only in IDLE.
- `x0` in 8: rectangle left column.
- `y0` in 7: rectangle top row.
- `w` in 8: width in pixels, 0..255.
- `h` in 7: height in pixels, 0..127.
- `colour_in` in 3: fill colour.
- `busy` out 1: high while in FILL.
- `done` out 1: one-cycle pulse when a command completes.
- `x` out 8: pixel column.
- `y` out 7: pixel row.
- `colour` out 3: pixel colour.
- `plot` out 1: pixel valid/write strobe.

## Operation
- One clock (`CLOCK_50`); reset is synchronous and active-high (`reset`).
- States:
  - IDLE: waits for `start`.
  - FILL: emits pixels.
  - The terminal transition goes FILL -> IDLE with `done`.
- IDLE, `start`=1: latch `x0`, `y0`, `w`, `h`, `colour_in`.
  - If `w`=0 or `h`=0: stay IDLE, pulse `done`, no plot.
  - Otherwise: go to FILL, clear col/row counters.
- FILL: each cycle, output `x`=x0+col (8-bit wrap), `y`=y0+row (7-bit wrap), `colour`=latched colour, `plot`=1.
  - col increments each cycle; at col=w-1 it resets to 0 and row increments.
  - At col=w-1, row=h-1: next state IDLE, `done`=1 for one cycle.
- Pixel order is row-major, left-to-right then top-to-bottom, exactly w*h pixels.
- `start` in FILL is ignored and not queued. `start` is accepted in the IDLE cycle where `done` is high (back-to-back commands).
- Input changes after acceptance have no effect.
- Reset values:
  - state IDLE.
  - `busy`, `done`, `plot` = 0.
  - `x`, `y`, `colour` = 0.
- Reset mid-FILL aborts the command: no `done`, and `plot`=0 from the following cycle.

## Timing
- All outputs are registered.
- `start` sampled at edge E with nonzero size:
  - `busy`=1 and pixel 0 appear after E.
  - Pixel i appears after edge E+i.
  - The last pixel appears after E+w*h-1.
  - After edge E+w*h: `busy`=0, `plot`=0, `done`=1 for one cycle.
- Zero-size command: `done`=1 after edge E; `busy` never rises.
- Throughput: one pixel per cycle, no stalls. There is no backpressure from the VGA port.
- `x`, `y` and `colour` hold their last value when `plot`=0.

## Configuration
- `VGA_RECT_CLIP_EN` defined:
  - A pixel with unwrapped x0+col >= `MAX_X` or y0+row >= `MAX_Y` has `plot` forced to 0.
  - Counters still step, so latency and `done` timing are unchanged.
  - Coordinates are computed with one extra bit for the compare.
- Undefined: no clipping; coordinates wrap modulo 256 (x) and 128 (y), and every pixel is plotted.

## Structure
- Shared package `vga_pkg`:
  - `X_W`=8, `Y_W`=7, `COLOUR_W`=3.
  - `colour_t` typedef.
  - Screen constants 160/120.
  - The `rect_state_t` enum (IDLE, FILL).
- One natural sub-module, `raster_counter`: col/row counters with width/height compare, producing `last` and `advance`. The FSM and output registers stay in `vga_rect_fill`.

## Test plan
- Basic fill: start with x0=10, y0=5, w=3, h=2, colour=4.
  - plot=1 for exactly 6 cycles, in order (10,5),(11,5),(12,5),(10,6),(11,6),(12,6), colour=4.
  - done after edge E+6; busy high for the 6 cycles.
- Zero size: w=0, h=5 -> done after E, no plot, busy stays 0. Repeat with w=4, h=0 for the same result.
- Busy-ignore: start a 4x4 fill, then assert start with different parameters during FILL -> exactly 16 pixels of the original command, one done pulse.
- Back-to-back:
  - 1x1 fill at (0,0), then start held in the done cycle with (5,5) 1x1.
  - Second pixel appears on the cycle after done, and a second done follows.
- Edge/clip: x0=158, y0=0, w=4, h=1.
  - Without the macro: x=158,159,160,161 all plotted.
  - With `VGA_RECT_CLIP_EN`: only 158 and 159 have plot=1.
  - done after E+4 in both builds.
- Reset mid-fill: assert reset during pixel 3 of a 5x5 fill -> next cycle all outputs 0, no done. A new start afterwards works normally.
